booth_divider: RTL
==================

BOOTH_DIVIDER -- requirements
Module: booth_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits; legal range 4..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous, active-low, sampled on rising clk.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: signed_en  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 SHALL have port: dividend  input  WIDTH  numerator; captured with start.
REQ-007 SHALL have port: divisor  input  WIDTH  denominator; captured with start.
REQ-008 SHALL have port: busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 SHALL have port: quotient  output  WIDTH  registered quotient, held until next done or reset.
REQ-011 SHALL have port: remainder  output  WIDTH  registered remainder, held until next done or reset.
REQ-012 SHALL have port: div_zero  output  1  divisor was zero; valid with done, held with results.
REQ-013 SHALL have port: overflow  output  1  signed most-negative / -1; valid with done, held with results.

Function
REQ-014 SHALL implement FSM states IDLE, DIV, FIX; transitions IDLE->DIV on accepted start with nonzero divisor, IDLE->FIX on accepted start with zero divisor, DIV->FIX when iteration counter reaches 0, FIX->IDLE unconditionally.
REQ-015 SHALL accept start only in IDLE; start while busy is ignored, with no effect on the operation in flight.
REQ-016 SHALL, on acceptance (edge N), latch operand magnitudes (absolute values when signed_en=1), quotient sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend), and load the iteration counter with WIDTH.
REQ-017 SHALL, in DIV, per cycle: shift {partial remainder, quotient register} left by 1, trial-subtract the divisor magnitude from the (WIDTH+1)-bit partial remainder; if non-negative keep the difference and set the quotient LSB to 1, else restore and set it to 0; decrement the counter.
REQ-018 SHALL, in FIX, apply the sign corrections, register quotient/remainder/flags, and assert done for exactly one cycle; busy deasserts in the same cycle.
REQ-019 SHALL have a latency of start edge N -> done high after edge N+WIDTH+1 for a nonzero divisor, and done high after edge N+1 for a zero divisor.
REQ-020 SHALL, on divide-by-zero, output quotient = all ones, remainder = dividend (unchanged), div_zero=1, overflow=0.
REQ-021 SHALL, when signed_en=1, dividend = most-negative value and divisor = -1, output quotient = most-negative value (wrapped), remainder = 0, overflow=1.
REQ-022 SHALL truncate toward zero: |quotient|*|divisor| + |remainder| = |dividend|, remainder is 0 or takes the dividend's sign, and |remainder| < |divisor|.
REQ-023 SHALL, when signed_en=0, treat all operands as unsigned; overflow is always 0.
REQ-024 SHALL accept a new start in the cycle after done (back-to-back throughput of one operation per WIDTH+2 cycles).

Reset
REQ-025 SHALL, with rst_n=0 at a rising edge, go to IDLE and clear busy, done, quotient, remainder, div_zero, overflow and the counter to 0.
REQ-026 SHALL abort any operation when reset is applied mid-DIV or in FIX; no done pulse is produced for the aborted operation.
REQ-027 SHALL ignore start in any cycle where rst_n=0.

Verification (WIDTH=16)
REQ-028 SHALL pass: signed 100 / 7 -> quotient 0x000E, remainder 0x0002, done exactly 17 cycles after the start edge.
REQ-029 SHALL pass: signed -100 / 7 -> quotient 0xFFF2, remainder 0xFFFE; signed 100 / -7 -> quotient 0xFFF2, remainder 0x0002.
REQ-030 SHALL pass: unsigned 0xFFFF / 0x0002 -> quotient 0x7FFF, remainder 0x0001, overflow 0.
REQ-031 SHALL pass: 5 / 0 -> done 1 cycle after start, quotient 0xFFFF, remainder 0x0005, div_zero 1.
REQ-032 SHALL pass: signed 0x8000 / 0xFFFF -> quotient 0x8000, remainder 0, overflow 1.
REQ-033 SHALL pass: rst_n low at iteration 8 -> outputs 0, no done pulse; then a start pulsed during busy in the next operation is ignored, and that operation's result is unchanged.

Source files
------------

// File: rtl/booth_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned
// operands, truncating toward zero, with divide-by-zero and overflow flags.
module booth_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
  logic             q_neg, r_neg, dz_q, ovf_q;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;

  assign busy = (state != IDLE);

  always_comb begin
    dvd_mag = (signed_en && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    dvs_mag = (signed_en && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == '0) ? FIX : DIV;
      DIV:  if (cnt == CW'(1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rem_q <= '0;
          quo_q <= dvd_mag;
          dvs_q <= dvs_mag;
          dvd_q <= dividend;
          q_neg <= signed_en & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg <= signed_en & dividend[WIDTH-1];
          dz_q  <= (divisor == '0);
          ovf_q <= signed_en && (dividend == MOST_NEG) && (divisor == '1);
          cnt   <= CW'(WIDTH);
        end
        DIV: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          // The most-negative / -1 case wraps naturally through the magnitude path.
          if (dz_q) begin
            quotient  <= '1;
            remainder <= dvd_q;
          end else begin
            quotient  <= q_neg ? (~quo_q + 1'b1) : quo_q;
            remainder <= r_neg ? (~rem_q + 1'b1) : rem_q;
          end
          div_zero <= dz_q;
          overflow <= ovf_q;
          done     <= 1'b1;
          cnt      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
